// File: rtl/ref_blk_addr_gen.sv
// Reference-block address sequencer: walks a clamped search window issuing (x, y, poc) per block.
// First address one cycle after start; holds while ready_in is low. Define REF_ADDR_GEN_SNAKE_EN for serpentine order.
module ref_blk_addr_gen #(
  parameter int BLOCK_HORI_SIZE = 8,
  parameter int BLOCK_VERT_SIZE = 8,
  parameter int IMG_WIDTH       = 1920,
  parameter int IMG_HEIGHT      = 1080,
  parameter int SRCH_HORI       = 64,
  parameter int SRCH_VERT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] ctr_x_in,
  input  logic [31:0] ctr_y_in,
  input  logic [31:0] pic_poc_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [31:0] x_address_out,
  output logic [31:0] y_address_out,
  output logic [31:0] pic_poc_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] blk_count_out
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [31:0] HALF_X   = 32'(SRCH_HORI / 2);
  localparam logic [31:0] HALF_Y   = 32'(SRCH_VERT / 2);
  localparam logic [31:0] MAX_X    = 32'(IMG_WIDTH - SRCH_HORI);
  localparam logic [31:0] MAX_Y    = 32'(IMG_HEIGHT - SRCH_VERT);
  localparam logic [31:0] MASK_X   = ~32'(BLOCK_HORI_SIZE - 1);
  localparam logic [31:0] MASK_Y   = ~32'(BLOCK_VERT_SIZE - 1);
  localparam logic [31:0] STEP_X   = 32'(BLOCK_HORI_SIZE);
  localparam logic [31:0] STEP_Y   = 32'(BLOCK_VERT_SIZE);
  localparam logic [15:0] LAST_COL = 16'(SRCH_HORI / BLOCK_HORI_SIZE - 1);
  localparam logic [15:0] LAST_BLK =
    16'((SRCH_HORI / BLOCK_HORI_SIZE) * (SRCH_VERT / BLOCK_VERT_SIZE) - 1);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] poc_q, poc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] col_q, col_d;
`ifdef REF_ADDR_GEN_SNAKE_EN
  logic        odd_q, odd_d;
`else
  logic [31:0] x0_q, x0_d;
`endif

  logic [31:0] x0_raw, y0_raw, x0_clamp, y0_clamp, x0_calc, y0_calc;

  // Compare before trusting the subtraction so an underflowed raw never escapes.
  always_comb begin
    x0_raw = ctr_x_in - HALF_X;
    y0_raw = ctr_y_in - HALF_Y;
    if (ctr_x_in < HALF_X)  x0_clamp = '0;
    else if (x0_raw > MAX_X) x0_clamp = MAX_X;
    else                     x0_clamp = x0_raw;
    if (ctr_y_in < HALF_Y)  y0_clamp = '0;
    else if (y0_raw > MAX_Y) y0_clamp = MAX_Y;
    else                     y0_clamp = y0_raw;
    x0_calc = x0_clamp & MASK_X;
    y0_calc = y0_clamp & MASK_Y;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    poc_d   = poc_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
`ifdef REF_ADDR_GEN_SNAKE_EN
    odd_d   = odd_q;
`else
    x0_d    = x0_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ISSUE;
          valid_d = 1'b1;
          x_d     = x0_calc;
          y_d     = y0_calc;
          poc_d   = pic_poc_in;
          cnt_d   = '0;
          col_d   = '0;
`ifdef REF_ADDR_GEN_SNAKE_EN
          odd_d   = 1'b0;
`else
          x0_d    = x0_calc;
`endif
        end
      end
      ISSUE: begin
        // valid_q is always high in ISSUE, so ready_in alone marks a transfer.
        if (ready_in) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_BLK) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            y_d   = y_q + STEP_Y;
`ifdef REF_ADDR_GEN_SNAKE_EN
            odd_d = ~odd_q;
`else
            x_d   = x0_q;
`endif
          end else begin
            col_d = col_q + 16'd1;
`ifdef REF_ADDR_GEN_SNAKE_EN
            x_d   = odd_q ? (x_q - STEP_X) : (x_q + STEP_X);
`else
            x_d   = x_q + STEP_X;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      poc_q   <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
`ifdef REF_ADDR_GEN_SNAKE_EN
      odd_q   <= 1'b0;
`else
      x0_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      poc_q   <= poc_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
`ifdef REF_ADDR_GEN_SNAKE_EN
      odd_q   <= odd_d;
`else
      x0_q    <= x0_d;
`endif
    end
  end

  assign valid_out     = valid_q;
  assign x_address_out = x_q;
  assign y_address_out = y_q;
  assign pic_poc_out   = poc_q;
  assign busy_out      = (state_q == ISSUE);
  assign done_out      = done_q;
  assign blk_count_out = cnt_q;

endmodule

// File: tb/tb_ref_blk_addr_gen.sv
// Directed bench for ref_blk_addr_gen: raster/serpentine walks, clamping, backpressure, reset, restart.
module tb_ref_blk_addr_gen;

  localparam int BLK    = 8;
  localparam int NCOL   = 8;
  localparam int NBLK   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [31:0] ctr_x_in, ctr_y_in, pic_poc_in;
  logic        ready_in;
  logic        valid_out, busy_out, done_out;
  logic [31:0] x_address_out, y_address_out, pic_poc_out;
  logic [15:0] blk_count_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] got_x [NBLK];
  logic [31:0] got_y [NBLK];

  ref_blk_addr_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start_in      (start_in),
    .ctr_x_in      (ctr_x_in),
    .ctr_y_in      (ctr_y_in),
    .pic_poc_in    (pic_poc_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .x_address_out (x_address_out),
    .y_address_out (y_address_out),
    .pic_poc_out   (pic_poc_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .blk_count_out (blk_count_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected address of block i from its row/column index.
  function automatic logic [31:0] exp_x(input logic [31:0] x0, input int i);
    int col;
    col = i % NCOL;
`ifdef REF_ADDR_GEN_SNAKE_EN
    if (((i / NCOL) % 2) == 1) col = NCOL - 1 - col;
`endif
    return x0 + 32'(BLK * col);
  endfunction

  function automatic logic [31:0] exp_y(input logic [31:0] y0, input int i);
    return y0 + 32'(BLK * (i / NCOL));
  endfunction

  // Called at a negedge while idle; returns at the negedge where done_out should be high.
  task automatic run_job(input string tag, input logic [31:0] cx, input logic [31:0] cy,
                         input logic [31:0] poc, input logic [31:0] ex0, input logic [31:0] ey0,
                         input int pulse_at);
    start_in   = 1'b1;
    ctr_x_in   = cx;
    ctr_y_in   = cy;
    pic_poc_in = poc;
    ready_in   = 1'b1;
    @(negedge clk);
    start_in   = 1'b0;
    pic_poc_in = 32'hDEAD_BEEF;
    check_eq({tag, " valid_rise"}, 32'(valid_out), 32'd1);
    check_eq({tag, " cnt_clr"}, 32'(blk_count_out), 32'd0);
    for (int i = 0; i < NBLK; i++) begin
      got_x[i] = x_address_out;
      got_y[i] = y_address_out;
      check_eq($sformatf("%s x[%0d]", tag, i), x_address_out, exp_x(ex0, i));
      check_eq($sformatf("%s y[%0d]", tag, i), y_address_out, exp_y(ey0, i));
      check_eq($sformatf("%s poc[%0d]", tag, i), pic_poc_out, poc);
      check_eq($sformatf("%s vld[%0d]", tag, i), 32'(valid_out), 32'd1);
      check_eq($sformatf("%s busy[%0d]", tag, i), 32'(busy_out), 32'd1);
      check_eq($sformatf("%s done[%0d]", tag, i), 32'(done_out), 32'd0);
      check_eq($sformatf("%s cnt[%0d]", tag, i), 32'(blk_count_out), 32'(i));
      if (i == pulse_at) begin
        start_in = 1'b1;
        ctr_x_in = 32'd10;
        ctr_y_in = 32'd20;
      end else begin
        start_in = 1'b0;
      end
      @(negedge clk);
    end
    start_in = 1'b0;
    check_eq({tag, " done"}, 32'(done_out), 32'd1);
    check_eq({tag, " vld_end"}, 32'(valid_out), 32'd0);
    check_eq({tag, " busy_end"}, 32'(busy_out), 32'd0);
    check_eq({tag, " cnt_end"}, 32'(blk_count_out), 32'd64);
    check_eq({tag, " x_hold"}, x_address_out, exp_x(ex0, NBLK - 1));
    check_eq({tag, " y_hold"}, y_address_out, exp_y(ey0, NBLK - 1));
  endtask

  // Runs the current job to completion with ready high, bounded.
  task automatic drain(input string tag);
    int n;
    n = 0;
    ready_in = 1'b1;
    while (!done_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " done_seen"}, 32'(done_out), 32'd1);
    check_eq({tag, " cnt_final"}, 32'(blk_count_out), 32'd64);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    start_in   = 1'b0;
    ready_in   = 1'b0;
    ctr_x_in   = '0;
    ctr_y_in   = '0;
    pic_poc_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst valid", 32'(valid_out), 32'd0);
    check_eq("rst x", x_address_out, 32'd0);
    check_eq("rst y", y_address_out, 32'd0);
    check_eq("rst poc", pic_poc_out, 32'd0);
    check_eq("rst busy", 32'(busy_out), 32'd0);
    check_eq("rst done", 32'(done_out), 32'd0);
    check_eq("rst cnt", 32'(blk_count_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Centre job
    run_job("ctr", 32'd960, 32'd540, 32'd3, 32'd928, 32'd504, -1);
    check_eq("ctr a1 x", got_x[0], 32'd928);
    check_eq("ctr a1 y", got_y[0], 32'd504);
    check_eq("ctr a8 x", got_x[7], 32'd984);
    check_eq("ctr a8 y", got_y[7], 32'd504);
`ifdef REF_ADDR_GEN_SNAKE_EN
    check_eq("snk a9 x", got_x[8], 32'd984);
    check_eq("snk a9 y", got_y[8], 32'd512);
    check_eq("snk a16 x", got_x[15], 32'd928);
    check_eq("snk a16 y", got_y[15], 32'd512);
    check_eq("snk a17 x", got_x[16], 32'd928);
    check_eq("snk a17 y", got_y[16], 32'd520);
    check_eq("snk a64 x", got_x[63], 32'd928);
`else
    check_eq("ctr a2 x", got_x[1], 32'd936);
    check_eq("ctr a9 x", got_x[8], 32'd928);
    check_eq("ctr a9 y", got_y[8], 32'd512);
    check_eq("ctr a64 x", got_x[63], 32'd984);
`endif
    check_eq("ctr a64 y", got_y[63], 32'd560);
    @(negedge clk);
    check_eq("idle done_low", 32'(done_out), 32'd0);
    check_eq("idle ready_noeffect", 32'(blk_count_out), 32'd64);
    check_eq("idle valid", 32'(valid_out), 32'd0);

    // Low corner clamp
    run_job("low", 32'd10, 32'd20, 32'd5, 32'd0, 32'd0, -1);
    check_eq("low first x", got_x[0], 32'd0);
    check_eq("low first y", got_y[0], 32'd0);
`ifdef REF_ADDR_GEN_SNAKE_EN
    check_eq("low last x", got_x[63], 32'd0);
`else
    check_eq("low last x", got_x[63], 32'd56);
`endif
    check_eq("low last y", got_y[63], 32'd56);
    @(negedge clk);

    // High corner clamp
    run_job("high", 32'd1910, 32'd1075, 32'd9, 32'd1856, 32'd1016, -1);
    check_eq("high first x", got_x[0], 32'd1856);
    check_eq("high first y", got_y[0], 32'd1016);
`ifdef REF_ADDR_GEN_SNAKE_EN
    check_eq("high last x", got_x[63], 32'd1856);
`else
    check_eq("high last x", got_x[63], 32'd1912);
`endif
    check_eq("high last y", got_y[63], 32'd1072);
    @(negedge clk);

    // Backpressure on the 5th address
    start_in   = 1'b1;
    ctr_x_in   = 32'd960;
    ctr_y_in   = 32'd540;
    pic_poc_in = 32'd4;
    ready_in   = 1'b1;
    @(negedge clk);
    start_in   = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("bp pre x", x_address_out, 32'd960);
    check_eq("bp pre cnt", 32'(blk_count_out), 32'd4);
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("bp vld %0d", k), 32'(valid_out), 32'd1);
      check_eq($sformatf("bp x %0d", k), x_address_out, 32'd960);
      check_eq($sformatf("bp y %0d", k), y_address_out, 32'd504);
      check_eq($sformatf("bp poc %0d", k), pic_poc_out, 32'd4);
      check_eq($sformatf("bp cnt %0d", k), 32'(blk_count_out), 32'd4);
    end
    ready_in = 1'b1;
    @(negedge clk);
    check_eq("bp post cnt", 32'(blk_count_out), 32'd5);
    check_eq("bp post x", x_address_out, 32'd968);
    check_eq("bp post y", y_address_out, 32'd504);
    drain("bp");

    // Reset after 10 transfers
    start_in   = 1'b1;
    ctr_x_in   = 32'd960;
    ctr_y_in   = 32'd540;
    pic_poc_in = 32'd6;
    ready_in   = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid cnt", 32'(blk_count_out), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid valid", 32'(valid_out), 32'd0);
    check_eq("mid busy", 32'(busy_out), 32'd0);
    check_eq("mid cnt0", 32'(blk_count_out), 32'd0);
    check_eq("mid x0", x_address_out, 32'd0);
    check_eq("mid poc0", pic_poc_out, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("mid nodone %0d", k), 32'(done_out), 32'd0);
      @(negedge clk);
    end
    run_job("post_rst", 32'd960, 32'd540, 32'd3, 32'd928, 32'd504, -1);
    @(negedge clk);

    // Start pulse mid-job ignored; start in done cycle accepted
    run_job("ign", 32'd960, 32'd540, 32'd11, 32'd928, 32'd504, 3);
    start_in   = 1'b1;
    ctr_x_in   = 32'd10;
    ctr_y_in   = 32'd20;
    pic_poc_in = 32'd7;
    @(negedge clk);
    start_in = 1'b0;
    check_eq("rst2 valid", 32'(valid_out), 32'd1);
    check_eq("rst2 busy", 32'(busy_out), 32'd1);
    check_eq("rst2 x", x_address_out, 32'd0);
    check_eq("rst2 y", y_address_out, 32'd0);
    check_eq("rst2 poc", pic_poc_out, 32'd7);
    check_eq("rst2 cnt", 32'(blk_count_out), 32'd0);
    check_eq("rst2 done", 32'(done_out), 32'd0);
    drain("rst2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
